fifo_ram_fft: RTL and testbench
===============================

FIFO_RAM_FFT -- requirements
Module: fifo_ram_fft

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter ADDR_WIDTH, default 10: address width; depth DEPTH = 2**ADDR_WIDTH (1024); legal range 4..10.
REQ-003 Parameter DATA_WIDTH, default 8: data word width; legal range 1..256.
REQ-004 Parameter OUT_REG, default 0: 1 adds one output register stage on rd_data.
REQ-005 Parameter ALMOST_FULL_NUM, default 11: almost_full threshold in words.
REQ-006 Parameter ALMOST_EMPTY_NUM, default 4: almost_empty threshold in words.
REQ-007 Port clk, input, 1: rising-edge clock for all logic.
REQ-008 Port rst_n, input, 1: synchronous active-low reset.
REQ-009 Port wr_data, input, DATA_WIDTH: write word.
REQ-010 Port wr_en, input, 1: write request.
REQ-011 Port full, output, 1: FIFO holds DEPTH words.
REQ-012 Port almost_full, output, 1: occupancy >= ALMOST_FULL_NUM.
REQ-013 Port rd_en, input, 1: read request, pops the head word.
REQ-014 Port rd_data, output, DATA_WIDTH: head-of-FIFO word (show-ahead).
REQ-015 Port empty, output, 1: FIFO holds zero words.
REQ-016 Port almost_empty, output, 1: occupancy <= ALMOST_EMPTY_NUM.

Function
REQ-017 A write SHALL occur on a rising clk edge when wr_en=1 and full=0; the word goes to mem[wr_ptr] and wr_ptr increments.
REQ-018 A read SHALL occur on a rising clk edge when rd_en=1 and empty=0; rd_ptr increments.
REQ-019 wr_en while full, and rd_en while empty, SHALL be ignored with no change to pointers, count, or memory.
REQ-020 Pointers SHALL be ADDR_WIDTH+1 bits and wrap modulo 2*DEPTH; the low ADDR_WIDTH bits address memory.
REQ-021 Occupancy count SHALL be a registered value (ADDR_WIDTH+1 bits): +1 on write only, -1 on read only, unchanged on a simultaneous write and read.
REQ-022 Simultaneous write and read when non-empty and non-full SHALL both take effect in the same cycle.
REQ-023 full, empty, almost_full and almost_empty SHALL be registered and SHALL update on the same edge as the count.
REQ-024 With OUT_REG=0, rd_data SHALL equal mem[rd_ptr] combinationally from the registered rd_ptr. After the edge on which a read pops word N, rd_data SHALL show word N+1.
REQ-025 With OUT_REG=1, rd_data SHALL be the OUT_REG=0 value delayed by one clk cycle through a register.
REQ-026 rd_data SHALL be don't-care while empty=1.
REQ-027 The first written word SHALL be visible on rd_data in the cycle after the write edge, when empty deasserts.

Reset
REQ-028 While rst_n=0 at a rising edge, the design SHALL set wr_ptr=0, rd_ptr=0, count=0, empty=1, almost_empty=1, full=0 and almost_full=0.
REQ-029 With OUT_REG=1, the rd_data register SHALL reset to 0.
REQ-030 Memory contents SHALL NOT be reset.
REQ-031 Reset asserted mid-operation SHALL discard all stored words.

Structure
REQ-032 A shared package SHALL hold the default DEPTH, DATA_WIDTH and threshold constants.
REQ-033 The memory SHALL be one sub-module, fifo_ram_fft_dpram: simple dual-port, one write port and one read port, same clock.
REQ-034 The flag and pointer logic SHALL reside in fifo_ram_fft.
REQ-035 No global-reset primitive SHALL be required inside the block.

Verification
REQ-036 Reset release, then 1024 writes of bytes 0,1,...,255 repeating -> full=1 after the 1024th write, almost_full=1 from occupancy 11, empty=0 one cycle after the first write.
REQ-037 From full, rd_en=1 for 1024 cycles -> rd_data equals a byte counter starting at 0 and incrementing each popped cycle; empty=1 after the last pop; almost_empty=1 at occupancy <= 4.
REQ-038 Write while full, with wr_data=0xAA -> count stays 1024 and the later read sequence contains no 0xAA.
REQ-039 Read while empty -> pointers unchanged; empty stays 1.
REQ-040 Occupancy 5, simultaneous wr_en=1 and rd_en=1 for 10 cycles -> count stays 5, and data order is preserved.
REQ-041 Occupancy 100, rst_n=0 for one edge -> empty=1, full=0, count=0; the next write of 0x5A reads back as 0x5A.

Source files
------------

// File: rtl/fifo_ram_fft_pkg.sv
// Shared defaults for the show-ahead FIFO and its RAM.
// Also holds the decoded per-cycle operation type.
package fifo_ram_fft_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH       = 10;
  localparam int unsigned DEFAULT_DEPTH            = 1 << DEFAULT_ADDR_WIDTH;
  localparam int unsigned DEFAULT_DATA_WIDTH       = 8;
  localparam int unsigned DEFAULT_ALMOST_FULL_NUM  = 11;
  localparam int unsigned DEFAULT_ALMOST_EMPTY_NUM = 4;

  // Encoded as {write accepted, read accepted}.
  typedef enum logic [1:0] {
    OpNone = 2'b00,
    OpRd   = 2'b01,
    OpWr   = 2'b10,
    OpBoth = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/fifo_ram_fft_dpram.sv
// Simple dual-port RAM: one synchronous write port and one combinational read port.
// Contents are never reset.
module fifo_ram_fft_dpram #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_ram_fft.sv
// Synchronous show-ahead FIFO with registered occupancy and flags.
// The head word is read combinationally, optionally through one output register.
module fifo_ram_fft
  import fifo_ram_fft_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH       = DEFAULT_DATA_WIDTH,
  parameter int unsigned OUT_REG          = 0,
  parameter int unsigned ALMOST_FULL_NUM  = DEFAULT_ALMOST_FULL_NUM,
  parameter int unsigned ALMOST_EMPTY_NUM = DEFAULT_ALMOST_EMPTY_NUM
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  almost_empty
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  typedef logic [ADDR_WIDTH:0] ptr_t;

  localparam ptr_t PtrOne   = ptr_t'(1);
  localparam ptr_t DepthCnt = ptr_t'(Depth);

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  ptr_t count_q, count_d;
  logic full_q, full_d;
  logic empty_q, empty_d;
  logic af_q, af_d;
  logic ae_q, ae_d;

  logic                  do_wr, do_rd;
  fifo_op_e              op;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign do_wr = wr_en & ~full_q;
  assign do_rd = rd_en & ~empty_q;
  assign op    = fifo_op_e'({do_wr, do_rd});

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    unique case (op)
      OpWr: begin
        wr_ptr_d = wr_ptr_q + PtrOne;
        count_d  = count_q + PtrOne;
      end
      OpRd: begin
        rd_ptr_d = rd_ptr_q + PtrOne;
        count_d  = count_q - PtrOne;
      end
      OpBoth: begin
        wr_ptr_d = wr_ptr_q + PtrOne;
        rd_ptr_d = rd_ptr_q + PtrOne;
      end
      default: ;
    endcase
    // Flags derive from the next count so they move on the same edge as it.
    full_d  = (count_d == DepthCnt);
    empty_d = (count_d == '0);
    af_d    = (32'(count_d) >= ALMOST_FULL_NUM);
    ae_d    = (32'(count_d) <= ALMOST_EMPTY_NUM);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
    end
  end

  fifo_ram_fft_dpram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_dpram (
    .clk  (clk),
    .we   (do_wr),
    .waddr(wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata(wr_data),
    .raddr(rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata(ram_rdata)
  );

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] rd_data_q;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rd_data_q <= '0;
      end else begin
        rd_data_q <= ram_rdata;
      end
    end
    assign rd_data = rd_data_q;
  end else begin : g_no_out_reg
    assign rd_data = ram_rdata;
  end

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;

endmodule

// File: tb/tb_fifo_ram_fft.sv
// Directed bench for fifo_ram_fft at default parameters (1024 x 8, no output register).
// A short vector table plus hand sequences for fill, drain, overflow, underflow and reset.
module tb_fifo_ram_fft;

  logic       clk_tb;
  logic       tb_rst;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full;
  logic       almost_full;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       almost_empty;

  int checks;
  int failures;

  fifo_ram_fft dut (
    .clk         (clk_tb),
    .rst_n       (tb_rst),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .full        (full),
    .almost_full (almost_full),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .empty       (empty),
    .almost_empty(almost_empty)
  );

  initial clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  typedef struct {
    logic       rst;
    logic       wr;
    logic       rd;
    logic [7:0] din;
    logic       e;
    logic       f;
    logic       ae;
    logic       af;
    logic       chk;
    logic [7:0] dout;
    int         cnt;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic r, input logic w, input logic rd, input logic [7:0] d);
    tb_rst  = r;
    wr_en   = w;
    rd_en   = rd;
    wr_data = d;
    @(posedge clk_tb);
    #1;
    tb_rst = 1'b1;
    wr_en  = 1'b0;
    rd_en  = 1'b0;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  logic [7:0] model_q[$];
  logic [7:0] exp_b;

  initial begin
    checks   = 0;
    failures = 0;
    tb_rst   = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    wr_data  = 8'h00;

    //          rst   wr    rd    din    e     f     ae    af    chk   dout   cnt
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 2};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 3};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'h44, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 4};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 5};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 5};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h33, 4};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h44, 3};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h77, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h5A, 1};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0};

    // Reset state
    do_reset();
    check("reset_empty", int'(empty), 1);
    check("reset_full", int'(full), 0);
    check("reset_almost_empty", int'(almost_empty), 1);
    check("reset_almost_full", int'(almost_full), 0);
    check("reset_count", int'(dut.count_q), 0);

    // Table-driven short sequence
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].din);
      check($sformatf("vec%0d_empty", i), int'(empty), int'(vecs[i].e));
      check($sformatf("vec%0d_full", i), int'(full), int'(vecs[i].f));
      check($sformatf("vec%0d_almost_empty", i), int'(almost_empty), int'(vecs[i].ae));
      check($sformatf("vec%0d_almost_full", i), int'(almost_full), int'(vecs[i].af));
      check($sformatf("vec%0d_count", i), int'(dut.count_q), vecs[i].cnt);
      if (vecs[i].chk) begin
        check($sformatf("vec%0d_rd_data", i), int'(rd_data), int'(vecs[i].dout));
      end
    end

    // Fill to full with a repeating byte ramp
    do_reset();
    for (int i = 0; i < 1024; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'(i));
      check("fill_empty", int'(empty), 0);
      check("fill_almost_full", int'(almost_full), (i + 1 >= 11) ? 1 : 0);
      check("fill_full", int'(full), (i + 1 == 1024) ? 1 : 0);
    end

    // Write while full is ignored
    step(1'b1, 1'b1, 1'b0, 8'hAA);
    check("ovf_count", int'(dut.count_q), 1024);
    check("ovf_full", int'(full), 1);
    check("ovf_wr_ptr", int'(dut.wr_ptr_q), 1024);

    // Drain, comparing the show-ahead head before each pop
    for (int i = 0; i < 1024; i++) begin
      exp_b = 8'(i);
      check("drain_rd_data", int'(rd_data), int'(exp_b));
      step(1'b1, 1'b0, 1'b1, 8'h00);
      check("drain_almost_empty", int'(almost_empty), (1023 - i <= 4) ? 1 : 0);
      check("drain_empty", int'(empty), (i == 1023) ? 1 : 0);
      check("drain_full", int'(full), 0);
    end

    // Read while empty is ignored
    step(1'b1, 1'b0, 1'b1, 8'h00);
    check("udf_empty", int'(empty), 1);
    check("udf_rd_ptr", int'(dut.rd_ptr_q), 1024);
    check("udf_wr_ptr", int'(dut.wr_ptr_q), 1024);
    check("udf_count", int'(dut.count_q), 0);

    // Occupancy 5 with 10 cycles of simultaneous read and write
    do_reset();
    model_q.delete();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'(8'hC0 + i));
      model_q.push_back(8'(8'hC0 + i));
    end
    for (int i = 0; i < 10; i++) begin
      check("rw_head", int'(rd_data), int'(model_q[0]));
      step(1'b1, 1'b1, 1'b1, 8'(8'hD0 + i));
      void'(model_q.pop_front());
      model_q.push_back(8'(8'hD0 + i));
      check("rw_count", int'(dut.count_q), 5);
    end
    for (int i = 0; i < 5; i++) begin
      check("rw_drain", int'(rd_data), int'(model_q[0]));
      void'(model_q.pop_front());
      step(1'b1, 1'b0, 1'b1, 8'h00);
    end
    check("rw_empty", int'(empty), 1);

    // Reset at occupancy 100 discards contents
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'(i + 3));
    end
    check("pre_rst_count", int'(dut.count_q), 100);
    do_reset();
    check("mid_rst_empty", int'(empty), 1);
    check("mid_rst_full", int'(full), 0);
    check("mid_rst_count", int'(dut.count_q), 0);
    step(1'b1, 1'b1, 1'b0, 8'h5A);
    check("post_rst_empty", int'(empty), 0);
    check("post_rst_rd_data", int'(rd_data), 8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
